// File: rtl/fp16_pair_packer.sv
// Packs a stream of FP16 elements into (a, b) operand pairs for the FP16 adder.
// An odd trailing element of a packet is padded with PAD_VALUE. Subnormals are
// optionally flushed to signed zero, and the bench-visible pair_count tracks
// every pair the adder accepts.
module fp16_pair_packer #(
  parameter logic [15:0] PAD_VALUE = 16'h0000,
  parameter bit          FTZ       = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_a,
  output logic [15:0]      m_b,
  output logic             m_last,
  output logic             m_pad,
  output logic [CNT_W-1:0] pair_count
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   m_a_d, m_b_d;
  logic                m_last_d, m_pad_d, m_valid_d;
  logic [CNT_W-1:0]    pair_count_d;

  logic                out_free;
  logic                acc;
  logic                drain;
  logic                load;
  logic [DATA_W-1:0]   x;

  // Handshake terms: the output slot is free when empty or being drained.
  assign out_free = !m_valid || m_ready;
  assign s_ready  = out_free && !flush;
  assign acc      = s_valid && s_ready;
  assign drain    = m_valid && m_ready;

  // Flush subnormals to signed zero since the adder always assumes a hidden 1.
  always_comb begin
    x = s_data;
    if (FTZ && (s_data[14:10] == 5'd0)) begin
      x = {s_data[15], 15'b0};
    end
  end

  // Next-state, hold register and output-register load decisions.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    load         = 1'b0;
    m_a_d        = m_a;
    m_b_d        = m_b;
    m_last_d     = m_last;
    m_pad_d      = m_pad;
    m_valid_d    = m_valid;
    pair_count_d = pair_count;

    if (flush) begin
      state_d = EMPTY;
    end else if (acc) begin
      unique case (state_q)
        EMPTY: begin
          if (s_last) begin
            load     = 1'b1;
            m_a_d    = x;
            m_b_d    = PAD_VALUE;
            m_last_d = 1'b1;
            m_pad_d  = 1'b1;
          end else begin
            hold_d  = x;
            state_d = HOLD;
          end
        end
        HOLD: begin
          load     = 1'b1;
          m_a_d    = hold_q;
          m_b_d    = x;
          m_last_d = s_last;
          m_pad_d  = 1'b0;
          state_d  = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end

    if (load) begin
      m_valid_d = 1'b1;
    end else if (drain) begin
      m_valid_d = 1'b0;
    end

    if (drain) begin
      pair_count_d = pair_count + CNT_W'(1);
    end
  end

  // State, hold and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      hold_q     <= '0;
      m_valid    <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      m_last     <= 1'b0;
      m_pad      <= 1'b0;
      pair_count <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      m_valid    <= m_valid_d;
      m_a        <= m_a_d;
      m_b        <= m_b_d;
      m_last     <= m_last_d;
      m_pad      <= m_pad_d;
      pair_count <= pair_count_d;
    end
  end

endmodule

// File: tb/tb_fp16_pair_packer.sv
// Directed bench for fp16_pair_packer. Two instances share the input stream:
// u0 uses defaults (FTZ on, zero pad, 16-bit count); u1 has FTZ off, a NaN pad
// and a 4-bit counter so the wrap is reachable in a short run.
module tb_fp16_pair_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_ready;

  logic        s_ready0, m_valid0, m_last0, m_pad0;
  logic [15:0] m_a0, m_b0, cnt0;
  logic        s_ready1, m_valid1, m_last1, m_pad1;
  logic [15:0] m_a1, m_b1;
  logic [3:0]  cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fp16_pair_packer u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid0), .m_ready(m_ready), .m_a(m_a0), .m_b(m_b0),
    .m_last(m_last0), .m_pad(m_pad0), .pair_count(cnt0)
  );

  fp16_pair_packer #(.PAD_VALUE(16'h7E00), .FTZ(1'b0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid1), .m_ready(m_ready), .m_a(m_a1), .m_b(m_b1),
    .m_last(m_last1), .m_pad(m_pad1), .pair_count(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    put(d, l);
    tick();
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_data  = 16'h0;
    s_last  = 1'b0;
    tick();
  endtask

  task automatic chk_pair(input string tag,
                          input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1,
                          input logic last, input logic pad);
    chk({tag, ".v0"},    32'(m_valid0), 32'd1);
    chk({tag, ".a0"},    32'(m_a0), 32'(a0));
    chk({tag, ".b0"},    32'(m_b0), 32'(b0));
    chk({tag, ".last0"}, 32'(m_last0), 32'(last));
    chk({tag, ".pad0"},  32'(m_pad0), 32'(pad));
    chk({tag, ".v1"},    32'(m_valid1), 32'd1);
    chk({tag, ".a1"},    32'(m_a1), 32'(a1));
    chk({tag, ".b1"},    32'(m_b1), 32'(b1));
    chk({tag, ".last1"}, 32'(m_last1), 32'(last));
    chk({tag, ".pad1"},  32'(m_pad1), 32'(pad));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] c0, input logic [3:0] c1);
    chk({tag, ".cnt0"}, 32'(cnt0), 32'(c0));
    chk({tag, ".cnt1"}, 32'(cnt1), 32'(c1));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".v0"}, 32'(m_valid0), 32'd0);
    chk({tag, ".v1"}, 32'(m_valid1), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = 16'h0; s_last = 1'b0; m_ready = 1'b1;
    #1;
    tick();
    tick();
    // Reset values
    chk_empty("rst");
    chk("rst.a0", 32'(m_a0), 32'h0);
    chk("rst.b1", 32'(m_b1), 32'h0);
    chk("rst.last0", 32'(m_last0), 32'd0);
    chk("rst.pad1", 32'(m_pad1), 32'd0);
    chk_cnt("rst", 16'd0, 4'd0);
    rst = 1'b0;
    #1;
    chk("rst.rdy0", 32'(s_ready0), 32'd1);

    // Even packet, back to back
    send(16'h3C00, 1'b0);
    chk_empty("t1.hold");
    send(16'h4000, 1'b0);
    chk_pair("t1.p1", 16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    send(16'h4200, 1'b0);
    chk_empty("t1.mid");
    chk_cnt("t1.mid", 16'd1, 4'd1);
    send(16'h4400, 1'b1);
    chk_pair("t1.p2", 16'h4200, 16'h4400, 16'h4200, 16'h4400, 1'b1, 1'b0);
    idle();
    chk_empty("t1.end");
    chk_cnt("t1.end", 16'd2, 4'd2);

    // Odd packet: trailing element padded, no bubble at the boundary
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    chk_pair("t2.p1", 16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    send(16'h4200, 1'b1);
    chk_pair("t2.p2", 16'h4200, 16'h0000, 16'h4200, 16'h7E00, 1'b1, 1'b1);
    chk_cnt("t2.p2", 16'd3, 4'd3);
    idle();
    chk_cnt("t2.end", 16'd4, 4'd4);

    // Subnormal flush (u0) versus pass-through (u1)
    send(16'h8001, 1'b0);
    send(16'h0200, 1'b1);
    chk_pair("t3.ftz", 16'h8000, 16'h0000, 16'h8001, 16'h0200, 1'b1, 1'b0);
    idle();
    chk_cnt("t3.end", 16'd5, 4'd5);

    // Backpressure
    send(16'h3C00, 1'b0);
    m_ready = 1'b0;
    send(16'h4000, 1'b0);
    put(16'h4200, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_pair("t4.stall", 16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 1'b0, 1'b0);
      #3;
      chk("t4.rdy0", 32'(s_ready0), 32'd0);
      chk("t4.rdy1", 32'(s_ready1), 32'd0);
      tick();
    end
    chk_cnt("t4.stall", 16'd5, 4'd5);
    m_ready = 1'b1;
    #3;
    chk("t4.rel.rdy0", 32'(s_ready0), 32'd1);
    tick();
    chk_empty("t4.rel");
    chk_cnt("t4.rel", 16'd6, 4'd6);
    send(16'h4400, 1'b1);
    chk_pair("t4.next", 16'h4200, 16'h4400, 16'h4200, 16'h4400, 1'b1, 1'b0);
    idle();
    chk_cnt("t4.end", 16'd7, 4'd7);

    // Flush drops the held element and refuses input that cycle
    send(16'h3C00, 1'b0);
    flush = 1'b1;
    put(16'h5555, 1'b0);
    #3;
    chk("t5.rdy0", 32'(s_ready0), 32'd0);
    chk("t5.rdy1", 32'(s_ready1), 32'd0);
    tick();
    flush = 1'b0;
    chk_empty("t5.fl");
    send(16'h4000, 1'b0);
    chk_empty("t5.hold");
    send(16'h4200, 1'b1);
    chk_pair("t5.pair", 16'h4000, 16'h4200, 16'h4000, 16'h4200, 1'b1, 1'b0);
    idle();
    chk_cnt("t5.end", 16'd8, 4'd8);

    // Counter wrap on the 4-bit instance with single-element packets
    for (int i = 0; i < 8; i++) begin
      send(16'(16'h3C00 + 16'(i)), 1'b1);
      chk_pair("t6.single", 16'(16'h3C00 + 16'(i)), 16'h0000,
               16'(16'h3C00 + 16'(i)), 16'h7E00, 1'b1, 1'b1);
    end
    chk_cnt("t6.pre", 16'd15, 4'd15);
    idle();
    chk_cnt("t6.wrap", 16'd16, 4'd0);

    // Reset with a stalled pending pair
    send(16'h3C00, 1'b0);
    m_ready = 1'b0;
    send(16'h4000, 1'b0);
    chk_pair("t7.pend", 16'h3C00, 16'h4000, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    chk_empty("t7.rst");
    chk("t7.a0", 32'(m_a0), 32'h0);
    chk("t7.b1", 32'(m_b1), 32'h0);
    chk_cnt("t7.rst", 16'd0, 4'd0);

    // Reset while holding: the held element must be lost
    send(16'h3C00, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_empty("t8.rst");
    send(16'h4000, 1'b1);
    chk_pair("t8.after", 16'h4000, 16'h0000, 16'h4000, 16'h7E00, 1'b1, 1'b1);
    idle();
    chk_cnt("t8.end", 16'd1, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
